control_unit: RTL and testbench

Multicycle FSM controller for the MIPS datapath: consumes the instruction-register opcode/funct fields and the ALU status flags, and drives every datapath control strobe (PC, memory, IR, register bank, ALU muxes, EPC). It is the control-side counterpart of the datapath's control wires. It supports R-type add/sub/and, addi, lw, sw, beq, bne and j, plus precise exceptions for invalid opcode and arithmetic overflow.

---
 rtl/cpu_ctrl_pkg.sv | 74 +++++++
 rtl/ctrl_alu_decode.sv | 35 +++
 rtl/control_unit.sv | 201 ++++++++++++++++++++
 tb/tb_control_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared types and encodings for the multicycle MIPS control
//                unit and the datapath mux decoders that consume its strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    // Controller states, one per multicycle step
    typedef enum logic [4:0] {
        ST_FETCH0 = 5'd0,
        ST_FETCH1 = 5'd1,
        ST_DECODE = 5'd2,
        ST_EXEC_R = 5'd3,
        ST_EXEC_I = 5'd4,
        ST_WB_R   = 5'd5,
        ST_WB_I   = 5'd6,
        ST_ADDR   = 5'd7,
        ST_MRD0   = 5'd8,
        ST_MRD1   = 5'd9,
        ST_WB_LW  = 5'd10,
        ST_MWR    = 5'd11,
        ST_BRANCH = 5'd12,
        ST_JUMP   = 5'd13,
        ST_EXC0   = 5'd14,
        ST_EXC1   = 5'd15,
        ST_EXC2   = 5'd16
    } state_t;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] c_fn_add = 6'h20;
    localparam logic [5:0] c_fn_sub = 6'h22;
    localparam logic [5:0] c_fn_and = 6'h24;

    // ALUControl codes
    localparam logic [2:0] c_alu_nop = 3'b000;
    localparam logic [2:0] c_alu_add = 3'b001;
    localparam logic [2:0] c_alu_sub = 3'b010;
    localparam logic [2:0] c_alu_and = 3'b011;

    // AluSrcB select
    localparam logic [1:0] c_srcb_reg    = 2'b00;
    localparam logic [1:0] c_srcb_four   = 2'b01;
    localparam logic [1:0] c_srcb_imm    = 2'b10;
    localparam logic [1:0] c_srcb_branch = 2'b11;

    // PCSource select
    localparam logic [1:0] c_pcs_alu    = 2'b00;
    localparam logic [1:0] c_pcs_aluout = 2'b01;
    localparam logic [1:0] c_pcs_jump   = 2'b10;
    localparam logic [1:0] c_pcs_exc    = 2'b11;

    // Exception cause / vector select
    localparam logic [1:0] c_exc_none   = 2'b00;
    localparam logic [1:0] c_exc_opcode = 2'b01;
    localparam logic [1:0] c_exc_ovf    = 2'b10;

    // True for the R-type function codes this controller implements
    function automatic logic is_rtype_funct(input logic [5:0] funct);
        return (funct == c_fn_add) || (funct == c_fn_sub) || (funct == c_fn_and);
    endfunction

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_alu_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_alu_decode
//  Description : Combinational ALU operation select from controller state and
//                the R-type function field.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_alu_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_control
);

    // Address/increment states add, compare/EPC states subtract, R-type follows FUNCT
    always_comb begin
        o_alu_control = c_alu_nop;
        case (i_state)
            ST_FETCH1, ST_DECODE, ST_EXEC_I, ST_ADDR: o_alu_control = c_alu_add;
            ST_BRANCH, ST_EXC0:                       o_alu_control = c_alu_sub;
            ST_EXEC_R: begin
                case (i_funct)
                    c_fn_add: o_alu_control = c_alu_add;
                    c_fn_sub: o_alu_control = c_alu_sub;
                    c_fn_and: o_alu_control = c_alu_and;
                    default:  o_alu_control = c_alu_nop;
                endcase
            end
            default: o_alu_control = c_alu_nop;
        endcase
    end

endmodule : ctrl_alu_decode
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Multicycle FSM controller for the MIPS datapath. Decodes the
//                IR opcode/funct fields and ALU flags into datapath strobes,
//                with precise exceptions for invalid opcode and overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_unit #(
    parameter logic [7:0] OVF_VECTOR = 8'd254,
    parameter logic [7:0] OPC_VECTOR = 8'd253
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       Overflow,
    input  logic       Zero,
    output logic       PCwrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       IorD,
    output logic       RegWrite,
    output logic       RegDest,
    output logic       MemToReg,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSource,
    output logic       EPCWrite,
    output logic [1:0] Exception
);
    import cpu_ctrl_pkg::*;

    // The datapath picks the handler address by cause, so both causes must
    // point at distinct vector bytes.
    generate
        if (OVF_VECTOR == OPC_VECTOR) begin : g_vector_clash
            $error("control_unit: OVF_VECTOR and OPC_VECTOR must differ");
        end
    endgenerate

    state_t     r_state;
    state_t     w_next_state;
    logic       r_ovf_q;
    logic [1:0] r_cause;
    logic       w_arith_ovf;

    ctrl_alu_decode u_alu_decode (
        .i_state       (r_state),
        .i_funct       (FUNCT),
        .o_alu_control (ALUControl)
    );

    // Overflow only matters for add/sub; "and" never traps
    assign w_arith_ovf = Overflow && ((ALUControl == c_alu_add) || (ALUControl == c_alu_sub));

    // State register, forced to FETCH0 asynchronously while reset is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_FETCH0;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Overflow flag from execute and exception cause captured on entry to EXC0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf_q <= 1'b0;
            r_cause <= c_exc_none;
        end else begin
            if ((r_state == ST_EXEC_R) || (r_state == ST_EXEC_I)) begin
                r_ovf_q <= w_arith_ovf;
            end
            if ((w_next_state == ST_EXC0) && (r_state != ST_EXC0)) begin
                r_cause <= (r_state == ST_DECODE) ? c_exc_opcode : c_exc_ovf;
            end
        end
    end

    // Next-state and Moore strobe decode; BRANCH PCwrite follows Zero directly
    always_comb begin
        w_next_state = ST_FETCH0;
        PCwrite      = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        IorD         = 1'b0;
        RegWrite     = 1'b0;
        RegDest      = 1'b0;
        MemToReg     = 1'b0;
        AluSrcA      = 1'b0;
        AluSrcB      = c_srcb_reg;
        PCSource     = c_pcs_alu;
        EPCWrite     = 1'b0;
        Exception    = c_exc_none;

        case (r_state)
            ST_FETCH0: begin
                w_next_state = ST_FETCH1;
            end
            ST_FETCH1: begin
                IRWrite      = 1'b1;
                PCwrite      = 1'b1;
                AluSrcB      = c_srcb_four;
                PCSource     = c_pcs_alu;
                w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                AluSrcB = c_srcb_branch;
                case (OPCODE)
                    c_op_rtype:       w_next_state = is_rtype_funct(FUNCT) ? ST_EXEC_R : ST_EXC0;
                    c_op_addi:        w_next_state = ST_EXEC_I;
                    c_op_lw, c_op_sw: w_next_state = ST_ADDR;
                    c_op_beq, c_op_bne: w_next_state = ST_BRANCH;
                    c_op_j:           w_next_state = ST_JUMP;
                    default:          w_next_state = ST_EXC0;
                endcase
            end
            ST_EXEC_R: begin
                AluSrcA      = 1'b1;
                AluSrcB      = c_srcb_reg;
                w_next_state = w_arith_ovf ? ST_EXC0 : ST_WB_R;
            end
            ST_EXEC_I: begin
                AluSrcA      = 1'b1;
                AluSrcB      = c_srcb_imm;
                w_next_state = w_arith_ovf ? ST_EXC0 : ST_WB_I;
            end
            ST_WB_R: begin
                RegWrite     = !r_ovf_q;
                RegDest      = 1'b1;
                w_next_state = ST_FETCH0;
            end
            ST_WB_I: begin
                RegWrite     = !r_ovf_q;
                w_next_state = ST_FETCH0;
            end
            ST_ADDR: begin
                AluSrcA      = 1'b1;
                AluSrcB      = c_srcb_imm;
                w_next_state = (OPCODE == c_op_sw) ? ST_MWR : ST_MRD0;
            end
            ST_MRD0: begin
                IorD         = 1'b1;
                w_next_state = ST_MRD1;
            end
            ST_MRD1: begin
                IorD         = 1'b1;
                MemRead      = 1'b1;
                w_next_state = ST_WB_LW;
            end
            ST_WB_LW: begin
                RegWrite     = 1'b1;
                MemToReg     = 1'b1;
                w_next_state = ST_FETCH0;
            end
            ST_MWR: begin
                IorD         = 1'b1;
                MemWrite     = 1'b1;
                w_next_state = ST_FETCH0;
            end
            ST_BRANCH: begin
                AluSrcA      = 1'b1;
                AluSrcB      = c_srcb_reg;
                PCSource     = c_pcs_aluout;
                PCwrite      = (OPCODE == c_op_bne) ? !Zero : Zero;
                w_next_state = ST_FETCH0;
            end
            ST_JUMP: begin
                PCSource     = c_pcs_jump;
                PCwrite      = 1'b1;
                w_next_state = ST_FETCH0;
            end
            ST_EXC0: begin
                AluSrcB      = c_srcb_four;
                EPCWrite     = 1'b1;
                Exception    = r_cause;
                IorD         = 1'b1;
                w_next_state = ST_EXC1;
            end
            ST_EXC1: begin
                Exception    = r_cause;
                IorD         = 1'b1;
                w_next_state = ST_EXC2;
            end
            ST_EXC2: begin
                PCSource     = c_pcs_exc;
                PCwrite      = 1'b1;
                w_next_state = ST_FETCH0;
            end
            default: begin
                w_next_state = ST_FETCH0;
            end
        endcase
    end

endmodule : control_unit
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit
//  Description : Self-checking bench for control_unit. A per-instruction
//                reference model lists the expected control word for every
//                cycle from fetch to the next fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    typedef logic [18:0] cw_t;
    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic       clk;
    logic       reset;
    logic [5:0] OPCODE;
    logic [5:0] FUNCT;
    logic       Overflow;
    logic       Zero;
    logic       PCwrite, MemRead, MemWrite, IRWrite, IorD, RegWrite, RegDest, MemToReg, AluSrcA, EPCWrite;
    logic [1:0] AluSrcB, PCSource, Exception;
    logic [2:0] ALUControl;

    int n_tests = 0;
    int n_fail  = 0;
    cw_t exp_q[$];
    cw_t obs;

    control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .OPCODE     (OPCODE),
        .FUNCT      (FUNCT),
        .Overflow   (Overflow),
        .Zero       (Zero),
        .PCwrite    (PCwrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .IorD       (IorD),
        .RegWrite   (RegWrite),
        .RegDest    (RegDest),
        .MemToReg   (MemToReg),
        .AluSrcA    (AluSrcA),
        .AluSrcB    (AluSrcB),
        .ALUControl (ALUControl),
        .PCSource   (PCSource),
        .EPCWrite   (EPCWrite),
        .Exception  (Exception)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {PCwrite, MemRead, MemWrite, IRWrite, IorD, RegWrite, RegDest, MemToReg,
                  AluSrcA, AluSrcB, ALUControl, PCSource, EPCWrite, Exception};

    // Pack one cycle's worth of strobes in the same order as obs
    function automatic cw_t cw(input logic pcw, input logic mr, input logic mw, input logic irw,
                               input logic iord, input logic rw, input logic rd, input logic m2r,
                               input logic asa, input logic [1:0] asb, input logic [2:0] alu,
                               input logic [1:0] pcs, input logic epcw, input logic [1:0] exc);
        return {pcw, mr, mw, irw, iord, rw, rd, m2r, asa, asb, alu, pcs, epcw, exc};
    endfunction

    // Reference model: the full per-cycle strobe sequence of one instruction
    task automatic build_expected(input logic [5:0] op, input logic [5:0] fn,
                                  input logic ovf, input logic zero);
        logic       trap;
        logic [1:0] cause;
        logic [2:0] alu;
        trap  = 1'b0;
        cause = 2'b00;
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back(cw(Y,N,N,Y,N,N,N,N,N,2'b01,3'b001,2'b00,N,2'b00));
        exp_q.push_back(cw(N,N,N,N,N,N,N,N,N,2'b11,3'b001,2'b00,N,2'b00));
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
            alu = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
            exp_q.push_back(cw(N,N,N,N,N,N,N,N,Y,2'b00,alu,2'b00,N,2'b00));
            if (ovf && fn != 6'h24) begin trap = 1'b1; cause = 2'b10; end
            else exp_q.push_back(cw(N,N,N,N,N,Y,Y,N,N,2'b00,3'b000,2'b00,N,2'b00));
        end else if (op == 6'h08) begin
            exp_q.push_back(cw(N,N,N,N,N,N,N,N,Y,2'b10,3'b001,2'b00,N,2'b00));
            if (ovf) begin trap = 1'b1; cause = 2'b10; end
            else exp_q.push_back(cw(N,N,N,N,N,Y,N,N,N,2'b00,3'b000,2'b00,N,2'b00));
        end else if (op == 6'h23) begin
            exp_q.push_back(cw(N,N,N,N,N,N,N,N,Y,2'b10,3'b001,2'b00,N,2'b00));
            exp_q.push_back(cw(N,N,N,N,Y,N,N,N,N,2'b00,3'b000,2'b00,N,2'b00));
            exp_q.push_back(cw(N,Y,N,N,Y,N,N,N,N,2'b00,3'b000,2'b00,N,2'b00));
            exp_q.push_back(cw(N,N,N,N,N,Y,N,Y,N,2'b00,3'b000,2'b00,N,2'b00));
        end else if (op == 6'h2B) begin
            exp_q.push_back(cw(N,N,N,N,N,N,N,N,Y,2'b10,3'b001,2'b00,N,2'b00));
            exp_q.push_back(cw(N,N,Y,N,Y,N,N,N,N,2'b00,3'b000,2'b00,N,2'b00));
        end else if (op == 6'h04 || op == 6'h05) begin
            exp_q.push_back(cw((op == 6'h04) ? zero : !zero,N,N,N,N,N,N,N,Y,2'b00,3'b010,2'b01,N,2'b00));
        end else if (op == 6'h02) begin
            exp_q.push_back(cw(Y,N,N,N,N,N,N,N,N,2'b00,3'b000,2'b10,N,2'b00));
        end else begin
            trap = 1'b1; cause = 2'b01;
        end
        if (trap) begin
            exp_q.push_back(cw(N,N,N,N,Y,N,N,N,N,2'b01,3'b010,2'b00,Y,cause));
            exp_q.push_back(cw(N,N,N,N,Y,N,N,N,N,2'b00,3'b000,2'b00,N,cause));
            exp_q.push_back(cw(Y,N,N,N,N,N,N,N,N,2'b00,3'b000,2'b11,N,2'b00));
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic ovf, input logic zero);
        OPCODE = op; FUNCT = fn; Overflow = ovf; Zero = zero;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        drive(6'h00, 6'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        n_tests++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 19'b0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_add;
        drive(6'h00, 6'h20, 1'b0, 1'b0);
        build_expected(6'h00, 6'h20, 1'b0, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL add cycle %0d: got %b expected %b", i, obs, exp_q[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addi_overflow;
        drive(6'h08, 6'h15, 1'b1, 1'b0);
        build_expected(6'h08, 6'h15, 1'b1, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL addi_ovf cycle %0d: got %b expected %b", i, obs, exp_q[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw;
        drive(6'h23, 6'h04, 1'b0, 1'b1);
        build_expected(6'h23, 6'h04, 1'b0, 1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL lw cycle %0d: got %b expected %b", i, obs, exp_q[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch;
        logic [5:0] ops [4];
        logic       zs  [4];
        ops = '{6'h04, 6'h05, 6'h04, 6'h05};
        zs  = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            drive(ops[k], 6'h00, 1'b0, zs[k]);
            build_expected(ops[k], 6'h00, 1'b0, zs[k]);
            for (int i = 0; i < exp_q.size(); i++) begin
                @(negedge clk);
                n_tests++;
                if (obs !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL branch op=%h zero=%b cycle %0d: got %b expected %b",
                             ops[k], zs[k], i, obs, exp_q[i]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_opcode_and_jump;
        logic [5:0] ops [3];
        logic [5:0] fns [3];
        ops = '{6'h3F, 6'h02, 6'h00};
        fns = '{6'h00, 6'h00, 6'h21};
        for (int k = 0; k < 3; k++) begin
            drive(ops[k], fns[k], 1'b0, 1'b0);
            build_expected(ops[k], fns[k], 1'b0, 1'b0);
            for (int i = 0; i < exp_q.size(); i++) begin
                @(negedge clk);
                n_tests++;
                if (obs !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL opc_jump op=%h fn=%h cycle %0d: got %b expected %b",
                             ops[k], fns[k], i, obs, exp_q[i]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    // Reset pulled low in the store cycle must kill MemWrite without a clock edge
    task automatic test_reset_mid_store;
        drive(6'h2B, 6'h00, 1'b0, 1'b0);
        build_expected(6'h2B, 6'h00, 1'b0, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL sw_pre_reset cycle %0d: got %b expected %b", i, obs, exp_q[i]);
            end
            if (i < exp_q.size() - 1) begin
                @(posedge clk); #1;
            end
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL async_reset_mwr: got %b expected %b", obs, 19'b0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        drive(6'h02, 6'h00, 1'b0, 1'b0);
        build_expected(6'h02, 6'h00, 1'b0, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL post_reset_j cycle %0d: got %b expected %b", i, obs, exp_q[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    // Random back-to-back instruction stream with random flags
    task automatic test_random;
        logic [5:0] op_pool [8];
        logic [5:0] fn_pool [4];
        logic [5:0] op, fn;
        logic       ovf, zero;
        op_pool = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h00};
        fn_pool = '{6'h20, 6'h22, 6'h24, 6'h00};
        for (int n = 0; n < 150; n++) begin
            op = op_pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
            fn = fn_pool[$urandom_range(0, 3)];
            if (fn == 6'h00) fn = 6'($urandom_range(0, 63));
            ovf  = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            drive(op, fn, ovf, zero);
            build_expected(op, fn, ovf, zero);
            for (int i = 0; i < exp_q.size(); i++) begin
                @(negedge clk);
                n_tests++;
                if (obs !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL random #%0d op=%h fn=%h ovf=%b z=%b cycle %0d: got %b expected %b",
                             n, op, fn, ovf, zero, i, obs, exp_q[i]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_addi_overflow();
        test_lw();
        test_branch();
        test_opcode_and_jump();
        test_reset_mid_store();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_control_unit
`default_nettype wire
